// File: rtl/data_mem_if.sv
// Data-memory port between the core's load/store path (master) and the memory responder (slave).
// req/ack: master raises req with we/addr/wdata stable and holds it until it samples ack=1.
// ack is a one-cycle pulse; rdata and err are valid only in that cycle.
interface data_mem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind a req/ack port with LATENCY programmable wait states.
// Flags misaligned and out-of-range accesses through err during the ack cycle.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus,
  output logic [1:0] dbg_state
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        cap_en;
  logic        access_en;
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        acc_err;
  logic [AW-1:0] acc_idx;

  logic [31:0] mem [DEPTH];

  // With LATENCY=0 the access happens on the accepting edge, so it must use
  // the live request fields; otherwise it uses the values captured at accept.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == IDLE) begin
      cur_we    = bus.we;
      cur_addr  = bus.addr;
      cur_wdata = bus.wdata;
    end
    acc_idx = cur_addr[2 +: AW];
    acc_err = (cur_addr[1:0] != 2'b00) || ({1'b0, cur_addr} >= LIMIT);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_en    = 1'b0;
    access_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          cap_en = 1'b1;
          if (LATENCY == 0) begin
            state_d   = RESP;
            access_en = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = RESP;
          access_en = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap_en) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (access_en) begin
        err_q <= acc_err;
        if (!cur_we) begin
          rdata_q <= acc_err ? 32'd0 : mem[acc_idx];
        end
      end
    end
  end

  // RAM has no reset: contents survive rst_n, and an aborted access never writes.
  always_ff @(posedge clk) begin
    if (access_en && cur_we && !acc_err) begin
      mem[acc_idx] <= cur_wdata;
    end
  end

  assign bus.ack   = (state_q == RESP);
  assign bus.err   = (state_q == RESP) && err_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 and LATENCY=0 instances,
// table of single accesses plus hand-written reset-abort, mid-change and back-to-back sequences.
module tb_data_mem_responder;

  logic       clk;
  logic       rst_n;
  logic [1:0] st2;
  logic [1:0] st0;

  data_mem_if m2();
  data_mem_if m0();

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (m2.slave),
    .dbg_state (st2)
  );

  data_mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (m0.slave),
    .dbg_state (st0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  // One access on the LATENCY=2 port. Inputs change on negedge, outputs sampled on negedge.
  task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic got_err, output logic [31:0] got_rdata, output int got_lat);
    @(negedge clk);
    m2.req = 1'b1; m2.we = w; m2.addr = a; m2.wdata = d;
    got_lat = -1; got_err = 1'bx; got_rdata = 32'hx;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (m2.ack) begin
        got_lat = c; got_err = m2.err; got_rdata = m2.rdata;
        break;
      end
    end
    m2.req = 1'b0;
  endtask

  logic        e;
  logic [31:0] r;
  int          lat;
  int          ack_cnt;

  initial begin
    rst_n = 1'b0;
    m2.req = 1'b0; m2.we = 1'b0; m2.addr = 32'd0; m2.wdata = 32'd0;
    m0.req = 1'b0; m0.we = 1'b0; m0.addr = 32'd0; m0.wdata = 32'd0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0013, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_0001, 1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hA5A5_0001};
    vecs[7]  = '{1'b1, 32'h0000_0020, 32'hCAFE_0020, 1'b0, 32'hA5A5_0001};
    vecs[8]  = '{1'b0, 32'h0000_0011, 32'h0,         1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b1, 32'h0000_0004, 32'h0000_0044, 1'b0, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h0000_0044};
    vecs[11] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hCAFE_0020};
    vecs[12] = '{1'b1, 32'hFFFF_FFFC, 32'h5555_5555, 1'b1, 32'hCAFE_0020};
    vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack",   {31'd0, m2.ack},  32'd0);
    check("rst_err",   {31'd0, m2.err},  32'd0);
    check("rst_busy",  {31'd0, m2.busy}, 32'd0);
    check("rst_rdata", m2.rdata,          32'd0);
    check("rst_state", {30'd0, st2},      32'd0);
    rst_n = 1'b1;

    // Table: every access on LATENCY=2, ack exactly 2 edges after the accepting edge
    for (int i = 0; i < 14; i++) begin
      run_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, e, r, lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_rdata", i), r, vecs[i].exp_rdata);
      @(negedge clk);
      check($sformatf("v%0d_ack_after", i), {31'd0, m2.ack}, 32'd0);
      check($sformatf("v%0d_busy_after", i), {31'd0, m2.busy}, 32'd0);
    end

    // Wait-state visibility: busy and WAIT state during the wait cycles
    @(negedge clk);
    m2.req = 1'b1; m2.we = 1'b0; m2.addr = 32'h10;
    @(posedge clk); @(negedge clk);
    check("wait_state", {30'd0, st2}, 32'd1);
    check("wait_busy",  {31'd0, m2.busy}, 32'd1);
    check("wait_ack",   {31'd0, m2.ack}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("wait2_ack",  {31'd0, m2.ack}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("resp_ack",   {31'd0, m2.ack}, 32'd1);
    check("resp_rdata", m2.rdata, 32'hDEAD_BEEF);
    m2.req = 1'b0;

    // Reset during WAIT aborts the store
    @(negedge clk);
    m2.req = 1'b1; m2.we = 1'b1; m2.addr = 32'h20; m2.wdata = 32'h0000_1234;
    @(posedge clk); @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ack",   {31'd0, m2.ack},  32'd0);
    check("abort_busy",  {31'd0, m2.busy}, 32'd0);
    check("abort_rdata", m2.rdata,          32'd0);
    m2.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m2.ack) ack_cnt++;
    end
    check("abort_no_ack", 32'(ack_cnt), 32'd0);
    run_access(1'b0, 32'h20, 32'h0, e, r, lat);
    check("abort_lat",   32'(lat), 32'd2);
    check("abort_rdata_prior", r, 32'hCAFE_0020);

    // Request fields changed mid-transaction are ignored
    run_access(1'b1, 32'h34, 32'h3434_3434, e, r, lat);
    @(negedge clk);
    m2.req = 1'b1; m2.we = 1'b1; m2.addr = 32'h30; m2.wdata = 32'h600D_0030;
    @(posedge clk); @(negedge clk);
    m2.we = 1'b0; m2.addr = 32'h34; m2.wdata = 32'h0000_0BAD;
    ack_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      if (m2.ack) begin
        ack_cnt++;
        check("mid_err", {31'd0, m2.err}, 32'd0);
        m2.req = 1'b0;
      end
    end
    check("mid_one_ack", 32'(ack_cnt), 32'd1);
    m2.req = 1'b0;
    run_access(1'b0, 32'h34, 32'h0, e, r, lat);
    check("mid_rdata_34", r, 32'h3434_3434);
    run_access(1'b0, 32'h30, 32'h0, e, r, lat);
    check("mid_rdata_30", r, 32'h600D_0030);

    // LATENCY=0, req held: ack/busy alternate every cycle
    @(negedge clk);
    m0.req = 1'b1; m0.we = 1'b1; m0.addr = 32'h8; m0.wdata = 32'h0000_0088;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("l0_ack%0d", i),  {31'd0, m0.ack},  {31'd0, (i % 2) == 0});
      check($sformatf("l0_busy%0d", i), {31'd0, m0.busy}, {31'd0, (i % 2) == 0});
    end
    m0.we = 1'b0;
    @(posedge clk); @(negedge clk);
    check("l0_load_ack",   {31'd0, m0.ack}, 32'd1);
    check("l0_load_err",   {31'd0, m0.err}, 32'd0);
    check("l0_load_rdata", m0.rdata, 32'h0000_0088);
    m0.req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("l0_idle_ack", {31'd0, m0.ack}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("l0_stay_idle", {31'd0, m0.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
